bcd_7seg_scan: RTL and testbench



---
 rtl/bcd_7seg_scan_if.sv | 22 ++
 rtl/bcd_7seg_scan.sv | 131 +++++++++++++
 tb/tb_bcd_7seg_scan.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bcd_7seg_scan_if.sv
// Bus between a datapath and the multiplexed 7-segment scanner: digits and load in, segment/enable lines out.
interface bcd_7seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_tick;

    modport master (
        output bcd_in, dp_in, load,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  bcd_in, dp_in, load,
        output seg, dp, an, frame_tick
    );
endinterface

// File: rtl/bcd_7seg_scan.sv
// Time-multiplexed BCD-to-7-segment scanner with shadow-latched digits and registered outputs.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module bcd_7seg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    bcd_7seg_scan_if.slave bus
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_dpShadow;
    logic [CNT_W-1:0]        r_scanCnt;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_wrapPending;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frameTick;

    logic                    w_advance;
    logic [3:0]              w_digit;
    logic                    w_dpSel;
    logic                    w_blank;
    logic [6:0]              w_segNext;
    logic [NUM_DIGITS-1:0]   w_anNext;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow   <= '0;
            r_dpShadow <= '0;
        end else if (bus.load) begin
            r_shadow   <= bus.bcd_in;
            r_dpShadow <= bus.dp_in;
        end
    end

    assign w_advance = (r_scanCnt == CNT_LAST);

    // r_wrapPending marks the first cycle idx is back at 0 so the output stage can pulse frame_tick in step with an.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scanCnt     <= '0;
            r_idx         <= '0;
            r_wrapPending <= 1'b0;
        end else begin
            r_wrapPending <= w_advance && (r_idx == IDX_LAST);
            if (w_advance) begin
                r_scanCnt <= '0;
                r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_scanCnt <= r_scanCnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_digit = 4'd0;
        w_dpSel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit = r_shadow[4*i +: 4];
                w_dpSel = r_dpShadow[i];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_zeroAbove;

    // Walk down from the most significant digit; a digit is blank while every digit from it upward is zero.
    always_comb begin
        w_blank     = 1'b0;
        w_zeroAbove = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_zeroAbove = w_zeroAbove & (r_shadow[4*i +: 4] == 4'd0);
            if (r_idx == IDX_W'(i)) begin
                w_blank = w_zeroAbove;
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    assign w_segNext = w_blank ? 7'b0000000 : decode(w_digit);
    assign w_anNext  = NUM_DIGITS'(1) << r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg       <= {7{ACTIVE_LOW}};
            r_dp        <= ACTIVE_LOW;
            r_an        <= {NUM_DIGITS{ACTIVE_LOW}};
            r_frameTick <= 1'b0;
        end else begin
            r_seg       <= w_segNext ^ {7{ACTIVE_LOW}};
            r_dp        <= w_dpSel ^ ACTIVE_LOW;
            r_an        <= w_anNext ^ {NUM_DIGITS{ACTIVE_LOW}};
            r_frameTick <= r_wrapPending;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.an         = r_an;
    assign bus.frame_tick = r_frameTick;
endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed bench for bcd_7seg_scan at NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=0; honours LEADING_ZERO_BLANK_EN.
module tb_bcd_7seg_scan;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   edgeNum = 0;
    logic [6:0] segTab [4];
    logic       dpTab  [4];

    bcd_7seg_scan_if #(.NUM_DIGITS(4)) bus ();

    bcd_7seg_scan #(
        .NUM_DIGITS(4),
        .SCAN_DIV  (4),
        .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic ld, input logic [15:0] bcd, input logic [3:0] dps);
        bus.load   = ld;
        bus.bcd_in = bcd;
        bus.dp_in  = dps;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        edgeNum++;
    endtask

    task automatic setTable(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                            input logic [6:0] s0, input logic [3:0] dps);
        segTab[0] = s0; segTab[1] = s1; segTab[2] = s2; segTab[3] = s3;
        for (int i = 0; i < 4; i++) dpTab[i] = dps[i];
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] expSeg, input logic expDp,
                               input logic [3:0] expAn, input logic expTick);
        total++;
        assert (bus.seg === expSeg) else begin
            bad++;
            $error("[TB] FAIL %s seg: got %b want %b", tag, bus.seg, expSeg);
        end
        total++;
        assert (bus.dp === expDp) else begin
            bad++;
            $error("[TB] FAIL %s dp: got %b want %b", tag, bus.dp, expDp);
        end
        total++;
        assert (bus.an === expAn) else begin
            bad++;
            $error("[TB] FAIL %s an: got %b want %b", tag, bus.an, expAn);
        end
        total++;
        assert (bus.frame_tick === expTick) else begin
            bad++;
            $error("[TB] FAIL %s frame_tick: got %b want %b", tag, bus.frame_tick, expTick);
        end
    endtask

    // After edge k from reset release the outputs show digit ((k-1)/4)%4; a frame starts every 16 edges from k=17.
    task automatic checkCycle();
        int d;
        d = ((edgeNum - 1) / 4) % 4;
        checkOutput($sformatf("edge%0d", edgeNum), segTab[d], dpTab[d], 4'(1 << d),
                    (edgeNum > 1) && ((edgeNum - 1) % 16 == 0));
    endtask

    task automatic setZeroTable();
`ifdef LEADING_ZERO_BLANK_EN
        setTable(7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110, 4'b0000);
`else
        setTable(7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 4'b0000);
`endif
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        repeat (3) @(negedge clk);
        checkOutput("reset", 7'b0000000, 1'b0, 4'b0000, 1'b0);

        rst = 1'b0;
        setZeroTable();
        for (int k = 1; k <= 5; k++) begin
            nextCycle();
            checkCycle();
        end

        applyStimulus(1'b1, 16'h1234, 4'b0100);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        checkCycle();
        setTable(7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 4'b0100);
        while (edgeNum < 64) begin
            nextCycle();
            checkCycle();
        end

        applyStimulus(1'b1, 16'hFA09, 4'b1000);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        checkCycle();
        setTable(7'b0000000, 7'b0000000, 7'b1111110, 7'b1111011, 4'b1000);
        while (edgeNum < 81) begin
            nextCycle();
            checkCycle();
        end

        applyStimulus(1'b1, 16'h0050, 4'b0000);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        checkCycle();
`ifdef LEADING_ZERO_BLANK_EN
        setTable(7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110, 4'b0000);
`else
        setTable(7'b1111110, 7'b1111110, 7'b1011011, 7'b1111110, 4'b0000);
`endif
        while (edgeNum < 98) begin
            nextCycle();
            checkCycle();
        end

        applyStimulus(1'b1, 16'h0000, 4'b0000);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        checkCycle();
        setZeroTable();
        while (edgeNum < 115) begin
            nextCycle();
            checkCycle();
        end

        rst = 1'b1;
        applyStimulus(1'b1, 16'h9999, 4'b1111);
        @(negedge clk);
        checkOutput("midReset", 7'b0000000, 1'b0, 4'b0000, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        edgeNum = 0;
        setZeroTable();
        while (edgeNum < 20) begin
            nextCycle();
            checkCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
